// File: rtl/ws2812_strip_serializer_if.sv
// Frame-RAM read port between the WS2812 serializer (master) and the frame memory (slave).
interface ws2812_strip_serializer_if #(
   parameter int unsigned ADDR_W = 13
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;

   modport master (output mem_rd_en, output mem_addr, input mem_data);
   modport slave  (input mem_rd_en, input mem_addr, output mem_data);
endinterface

// File: rtl/ws2812_strip_serializer.sv
// Streams one frame of GRB bytes from the frame RAM onto the WS2812 data pin,
// MSB first with gapless bit timing, followed by the latch gap.
module ws2812_strip_serializer #(
   parameter int unsigned NUM_BYTES = 216,
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned T0H       = 20,
   parameter int unsigned T1H       = 40,
   parameter int unsigned TBIT      = 62,
   parameter int unsigned TRESET    = 3000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   ws2812_strip_serializer_if.master        mem,
   output logic                             strip_out,
   output logic                             busy,
   output logic                             frame_done
);
   localparam int unsigned CYC_W = $clog2(TRESET + 1);
   localparam logic [CYC_W-1:0]  BIT_LAST  = CYC_W'(TBIT - 1);
   localparam logic [CYC_W-1:0]  RST_LAST  = CYC_W'(TRESET - 1);
   localparam logic [ADDR_W-1:0] BYTE_LAST = ADDR_W'(NUM_BYTES - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;

   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic [2:0]        bit_q, bit_d;
   logic [ADDR_W-1:0] byte_q, byte_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        hold_q, hold_d;
   logic              rd_q;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              strip_q, strip_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         hold_q  <= '0;
         rd_q    <= 1'b0;
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         strip_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         hold_q  <= hold_d;
         rd_q    <= rd_en_q;
         rd_en_q <= rd_en_d;
         addr_q  <= addr_d;
         strip_q <= strip_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      hold_d  = rd_q ? mem.mem_data : hold_q;
      rd_en_d = 1'b0;
      addr_d  = addr_q;
      strip_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (enable) begin
               state_d = FETCH;
               rd_en_d = 1'b1;
               addr_d  = '0;
               byte_d  = '0;
               busy_d  = 1'b1;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            shift_d = mem.mem_data;
            bit_d   = 3'd7;
            cyc_d   = '0;
            strip_d = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (cyc_q == BIT_LAST) begin
               cyc_d = '0;
               if (bit_q == 3'd0) begin
                  if (byte_q == BYTE_LAST) begin
                     state_d = LATCH;
                     done_d  = (TRESET == 1);
                  end else begin
                     shift_d = hold_q;
                     bit_d   = 3'd7;
                     byte_d  = byte_q + ADDR_W'(1);
                     strip_d = 1'b1;
                  end
               end else begin
                  shift_d = {shift_q[6:0], 1'b0};
                  bit_d   = bit_q - 3'd1;
                  strip_d = 1'b1;
                  // Prefetch the next byte during the first cycle of bit 0
                  if (bit_q == 3'd1 && byte_q != BYTE_LAST) begin
                     rd_en_d = 1'b1;
                     addr_d  = byte_q + ADDR_W'(1);
                  end
               end
            end else begin
               cyc_d   = cyc_q + CYC_W'(1);
               strip_d = (32'(cyc_q) + 32'd1) < (shift_q[7] ? T1H : T0H);
            end
         end
         LATCH: begin
            if (cyc_q == RST_LAST) begin
               state_d = IDLE;
               cyc_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cyc_d  = cyc_q + CYC_W'(1);
               done_d = (32'(cyc_q) + 32'd2 == TRESET);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem.mem_rd_en = rd_en_q;
   assign mem.mem_addr  = addr_q;
   assign strip_out     = strip_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;
endmodule

// File: tb/tb_ws2812_strip_serializer.sv
// Randomized bench for ws2812_strip_serializer: a frame-time model predicts every
// output cycle, and measured pulse/read timings are pinned against literal values.
module tb_ws2812_strip_serializer;
   localparam int unsigned NB        = 6;
   localparam int unsigned AW        = 13;
   localparam int unsigned T0H       = 20;
   localparam int unsigned T1H       = 40;
   localparam int unsigned TBIT      = 62;
   localparam int unsigned TRESET    = 200;
   localparam int          SEND_LEN  = int'(NB * 8 * TBIT);
   localparam int          FRAME_LEN = 2 + SEND_LEN + int'(TRESET);

   logic clk, rst, enable;
   logic strip_out, busy, frame_done;
   logic [7:0] ram [NB];

   ws2812_strip_serializer_if #(.ADDR_W(AW)) mif ();

   ws2812_strip_serializer #(
      .NUM_BYTES(NB), .ADDR_W(AW), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mem(mif),
      .strip_out(strip_out), .busy(busy), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read frame RAM
   always @(posedge clk) if (mif.mem_rd_en) mif.mem_data <= ram[mif.mem_addr];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_no   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   // Model: frame-relative time drives every expected output
   logic       m_active = 1'b0;
   int         m_t = 0;
   logic [7:0] m_mem [NB];

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_active = 1'b0;
         m_t = 0;
      end else begin
         cyc_no++;
         if (!m_active) begin
            if (enable) begin
               m_active = 1'b1;
               m_t = 0;
               m_mem = ram;
            end
         end else begin
            m_t++;
            if (m_t == FRAME_LEN) m_active = 1'b0;
         end
      end
   end

   function automatic logic [31:0] exp_vec(input logic act, input int t);
      int u, bi, pos, by;
      logic s, r;
      logic [AW-1:0] a;
      s = 1'b0; r = 1'b0; a = '0;
      if (!act) return 32'd0;
      if (t == 0) r = 1'b1;
      if (t >= 2 && t < 2 + SEND_LEN) begin
         u = t - 2; bi = u / int'(TBIT); pos = u % int'(TBIT); by = bi / 8;
         s = (pos < int'(m_mem[by][7 - bi % 8] ? T1H : T0H));
         if (bi % 8 == 7 && pos == 0 && by < int'(NB) - 1) begin
            r = 1'b1;
            a = AW'(by + 1);
         end
      end
      return {15'd0, s, 1'b1, (t == FRAME_LEN - 1), r, a};
   endfunction

   // Per-cycle output comparison
   initial forever begin
      logic [31:0] act;
      @(negedge clk);
      act = {15'd0, strip_out, busy, frame_done, mif.mem_rd_en,
             (mif.mem_rd_en ? mif.mem_addr : AW'(0))};
      check("outputs", act, exp_vec(m_active, m_t));
   end

   // Pulse and read-strobe recorder
   int   rise_q[$], width_q[$], rd_t_q[$], rd_a_q[$], done_t_q[$];
   logic prev_strip = 1'b0;
   initial forever begin
      @(negedge clk);
      if (rst) prev_strip = 1'b0;
      else begin
         if (strip_out && !prev_strip) rise_q.push_back(cyc_no);
         if (!strip_out && prev_strip && rise_q.size() > 0)
            width_q.push_back(cyc_no - rise_q[rise_q.size() - 1]);
         if (mif.mem_rd_en) begin
            rd_t_q.push_back(cyc_no);
            rd_a_q.push_back(int'(mif.mem_addr));
         end
         if (frame_done) done_t_q.push_back(cyc_no);
         prev_strip = strip_out;
      end
   end

   task automatic clear_rec();
      rise_q.delete(); width_q.delete(); rd_t_q.delete(); rd_a_q.delete(); done_t_q.delete();
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!frame_done && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_timeout", 32'(frame_done), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, rel, k;
      rst = 1'b1;
      enable = 1'b0;
      foreach (ram[i]) ram[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs", {28'd0, strip_out, busy, frame_done, mif.mem_rd_en}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Known data across a byte boundary, back-to-back frames
      ram[0] = 8'h80; ram[1] = 8'h01; ram[2] = 8'h80;
      clear_rec();
      enable = 1'b1;
      wait_done(5000);
      repeat (3) @(negedge clk);
      enable = 1'b0;
      wait_done(5000);
      repeat (300) @(negedge clk);
      check("pulse_count", 32'(rise_q.size()), 32'd96);
      check("width0", 32'(width_q[0]), 32'd40);
      check("width1", 32'(width_q[1]), 32'd20);
      check("width7", 32'(width_q[7]), 32'd20);
      check("width15", 32'(width_q[15]), 32'd40);
      check("width16", 32'(width_q[16]), 32'd40);
      check("rise_gap0", 32'(rise_q[1] - rise_q[0]), 32'd62);
      check("rise_gap_byte", 32'(rise_q[16] - rise_q[15]), 32'd62);
      check("start_latency", 32'(rise_q[0] - rd_t_q[0]), 32'd2);
      check("read_count", 32'(rd_t_q.size()), 32'd12);
      check("prefetch_addr", 32'(rd_a_q[1]), 32'd1);
      check("prefetch_time", 32'(rd_t_q[1] - rise_q[7]), 32'd0);
      check("frame_period", 32'(rd_t_q[6] - rd_t_q[0]), 32'd3179);
      check("restart_addr", 32'(rd_a_q[6]), 32'd0);
      check("done_time", 32'(done_t_q[0] - rd_t_q[0]), 32'd3177);
      check("done_count", 32'(done_t_q.size()), 32'd2);
      check("idle_after", 32'(busy), 32'd0);

      // Single-cycle enable pulse
      foreach (ram[i]) ram[i] = 8'($urandom);
      clear_rec();
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      wait_done(5000);
      repeat (300) @(negedge clk);
      check("pulse_pulses", 32'(rise_q.size()), 32'd48);
      check("pulse_reads", 32'(rd_t_q.size()), 32'd6);
      check("pulse_done", 32'(done_t_q.size()), 32'd1);
      check("pulse_idle", 32'(busy), 32'd0);

      // Random data and random enable activity
      for (int f = 0; f < 3; f++) begin
         foreach (ram[i]) ram[i] = 8'($urandom);
         n = int'($urandom_range(500, 4000));
         for (int c = 0; c < n; c++) begin
            @(negedge clk);
            enable = 1'($urandom_range(0, 1));
         end
         enable = 1'b0;
         wait_idle(8000);
         repeat (5) @(negedge clk);
      end

      // Reset in the middle of a high pulse, then restart
      foreach (ram[i]) ram[i] = 8'($urandom);
      enable = 1'b1;
      repeat (700) @(negedge clk);
      k = 0;
      while (!strip_out && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("pre_reset_high", 32'(strip_out), 32'd1);
      #2 rst = 1'b1;
      #1 check("async_reset", {29'd0, strip_out, busy, mif.mem_rd_en}, 32'd0);
      repeat (2) @(negedge clk);
      clear_rec();
      rel = cyc_no;
      rst = 1'b0;
      k = 0;
      while (rise_q.size() == 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("restart_seen", 32'(rise_q.size() > 0), 32'd1);
      if (rise_q.size() > 0 && rd_t_q.size() > 0) begin
         check("restart_read_addr", 32'(rd_a_q[0]), 32'd0);
         check("restart_read_time", 32'(rd_t_q[0] - rel), 32'd1);
         check("restart_latency", 32'(rise_q[0] - rd_t_q[0]), 32'd2);
      end
      enable = 1'b0;
      wait_done(5000);
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
